mw_countdown_timer: RTL and testbench
=====================================

# mw_countdown_timer

Microwave cook-time countdown in BCD minutes:seconds, directly downstream of the clock-division stage. It takes the one-second enable produced by the divider chain, loads a MM:SS value from the keypad encoder path, counts down while running and flags completion. Its outputs drive the display and the magnetron/lamp control logic.

## Interface
- Parameters: none. Format is fixed at MM:SS, range 00:00–99:59.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle-wide, one-second enable from the divider chain; synchronous to clk.
- load  in  1  capture load_mm/load_ss into the count.
- load_mm  in  8  minutes as two BCD digits: [7:4] tens, [3:0] ones.
- load_ss  in  8  seconds as two BCD digits: [7:4] tens, [3:0] ones.
- start  in  1  begin or resume counting.
- stop  in  1  pause counting; the count is held.
- clear  in  1  synchronous return to 00:00 and IDLE.
- mm  out  8  current minutes, BCD.
- ss  out  8  current seconds, BCD.
- running  out  1  high while in RUN.
- zero  out  1  high when count == 00:00.
- done  out  1  one-cycle pulse when the countdown reaches 00:00 from RUN.

## Operation
- States and encoding: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3.
- Command priority, applied per cycle: clear > load > stop > start > tick.
- clear: count := 00:00, state := IDLE. Allowed in every state.
- load: allowed in IDLE, PAUSE and DONE. Captures the input digits and sets state := IDLE. Ignored in RUN.
- Load sanitising: any ones digit >9 becomes 9. Seconds tens >5 becomes 5. Minutes tens >9 becomes 9.
- start:
  - IDLE or PAUSE with count ≠ 0 goes to RUN.
  - Ignored when count == 0.
  - Ignored in DONE.
- stop: RUN goes to PAUSE. Ignored in other states.
- tick in RUN decrements the count by one second through the BCD borrow chain:
  - ss ones 0 → 9, borrow into ss tens.
  - ss tens 0 → 5, borrow into mm ones.
  - mm ones 0 → 9, borrow into mm tens.
- Count reaching 00:00: the tick that turns 00:01 into 00:00 also sets state := DONE and pulses done.
- tick outside RUN: no effect.
- DONE: count is held at 00:00. The state is left only by clear or load.
- Outputs are registered or decoded directly from state:
  - running = (state == RUN).
  - zero = (count == 0).

## Timing
- Reset values: mm=8'h00, ss=8'h00, state=IDLE, running=0, zero=1, done=0.
- tick asserted in cycle n: the new count is visible after edge n+1, one cycle of latency.
- done rises on the same edge that count becomes 00:00 and stays high for exactly one cycle.
- start and stop take effect on the next edge. A tick in the same cycle as stop is lost; the count is not decremented.
- start with a coincident tick in PAUSE: the state changes to RUN, but that tick is not counted.
- load/clear with a coincident tick: the tick is discarded.
- rst_n asserted mid-run forces reset values immediately, without waiting for clk. Deassertion is synchronised externally.
- Wrap-around below 00:00 never occurs.

## Structure
- A shared header holds the state encodings and the BCD limit constants: 4'd9, 4'd5.
- Sub-module bcd_digit_dn, instantiated four times:
  - Inputs: en, a 4-bit max value, load, load value.
  - Outputs: the 4-bit digit and borrow_out, asserted when en is high and the digit is 0.
- The top level holds the FSM, the command priority, the sanitising logic, and zero/done generation.

## Test plan
- Reset, then load 01:05, start, 5 ticks → 01:00; 1 more tick → 00:59; running=1 throughout.
- Load 00:02, start, 2 ticks → 00:00; done high exactly one cycle; state DONE; further ticks and start ignored.
- Load 10:00, start, 1 tick → 09:59, exercising borrow across all four digits.
- Load 03:00, start, 1 tick → 02:59. Then stop with a coincident tick → count stays 02:59. Then 3 ticks in PAUSE → unchanged. Then start plus 1 tick → 02:58.
- Load mm=8'h7C, ss=8'h9F → count 79:59 after sanitising. Start with count 00:00 → stays IDLE.
- Run at 05:30 and drop rst_n between edges → outputs at reset values immediately. Clear during RUN → 00:00, IDLE, no done pulse.

Source files
------------

// File: rtl/mw_countdown_timer_pkg.sv
// Shared encodings and BCD limits for the microwave cook-time countdown.
package mw_countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX_ONES = 4'd9;
  localparam logic [3:0] BCD_MAX_TENS = 4'd5;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

endpackage

// File: rtl/mw_countdown_timer_bcd_digit_dn.sv
// One BCD down-counting digit: wraps 0 -> max_val on en and flags a borrow to the next digit.
module mw_countdown_timer_bcd_digit_dn (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] max_val,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] digit,
  output logic       borrow_out
);

  logic [3:0] digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_val;
    end else if (en) begin
      digit_d = (digit_q == 4'd0) ? max_val : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit      = digit_q;
  assign borrow_out = en && (digit_q == 4'd0);

endmodule

// File: rtl/mw_countdown_timer.sv
// MM:SS BCD cook-time countdown: one highest-priority command per cycle (clear > load > stop > start > tick).
// Count and done update one edge after the command; running/zero decode directly from registers.
module mw_countdown_timer
  import mw_countdown_timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       running,
  output logic       zero,
  output logic       done
);

  state_e      state_q, state_d;
  logic        done_q, done_d;
  logic        dec_en;
  logic        dig_ld;
  logic [15:0] dig_ld_val;
  logic [15:0] load_san;
  logic [3:0]  ss1, ss10, mm1, mm10;
  logic        b_ss1, b_ss10, b_mm1, borrow_unused;
  logic        zero_w, one_left;

  assign load_san = {bcd_clamp(load_mm[7:4], BCD_MAX_ONES),
                     bcd_clamp(load_mm[3:0], BCD_MAX_ONES),
                     bcd_clamp(load_ss[7:4], BCD_MAX_TENS),
                     bcd_clamp(load_ss[3:0], BCD_MAX_ONES)};

  assign zero_w   = ({mm10, mm1, ss10, ss1} == 16'h0000);
  assign one_left = ({mm10, mm1, ss10, ss1} == 16'h0001);

  // Only the highest-priority asserted command acts; lower ones in the same cycle are dropped,
  // even when the winning command is itself ignored in the current state.
  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    dec_en     = 1'b0;
    dig_ld     = 1'b0;
    dig_ld_val = load_san;
    if (clear) begin
      state_d    = ST_IDLE;
      dig_ld     = 1'b1;
      dig_ld_val = 16'h0000;
    end else if (load) begin
      if (state_q != ST_RUN) begin
        state_d = ST_IDLE;
        dig_ld  = 1'b1;
      end
    end else if (stop) begin
      if (state_q == ST_RUN) state_d = ST_PAUSE;
    end else if (start) begin
      if ((state_q == ST_IDLE || state_q == ST_PAUSE) && !zero_w) state_d = ST_RUN;
    end else if (tick && state_q == ST_RUN && !zero_w) begin
      dec_en = 1'b1;
      if (one_left) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  mw_countdown_timer_bcd_digit_dn u_ss1 (
    .clk(clk), .rst_n(rst_n), .en(dec_en), .max_val(BCD_MAX_ONES),
    .load(dig_ld), .load_val(dig_ld_val[3:0]), .digit(ss1), .borrow_out(b_ss1)
  );

  mw_countdown_timer_bcd_digit_dn u_ss10 (
    .clk(clk), .rst_n(rst_n), .en(b_ss1), .max_val(BCD_MAX_TENS),
    .load(dig_ld), .load_val(dig_ld_val[7:4]), .digit(ss10), .borrow_out(b_ss10)
  );

  mw_countdown_timer_bcd_digit_dn u_mm1 (
    .clk(clk), .rst_n(rst_n), .en(b_ss10), .max_val(BCD_MAX_ONES),
    .load(dig_ld), .load_val(dig_ld_val[11:8]), .digit(mm1), .borrow_out(b_mm1)
  );

  // The count never decrements from 00:00, so the top digit never borrows.
  mw_countdown_timer_bcd_digit_dn u_mm10 (
    .clk(clk), .rst_n(rst_n), .en(b_mm1), .max_val(BCD_MAX_ONES),
    .load(dig_ld), .load_val(dig_ld_val[15:12]), .digit(mm10), .borrow_out(borrow_unused)
  );

  assign mm      = {mm10, mm1};
  assign ss      = {ss10, ss1};
  assign running = (state_q == ST_RUN);
  assign zero    = zero_w;
  assign done    = done_q;

endmodule

// File: tb/tb_mw_countdown_timer.sv
// Bench for mw_countdown_timer: per-cycle vector table plus an asynchronous-reset sequence.
module tb_mw_countdown_timer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic [7:0] load_mm = 8'h00, load_ss = 8'h00;
  logic [7:0] mm, ss;
  logic       running, zero, done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       tick, load;
    logic [7:0] lmm, lss;
    logic       start, stop, clear;
    logic [7:0] emm, ess;
    logic       erun, ezero, edone;
  } vec_t;

  typedef logic [18:0] obs_t;
  obs_t exp_q[$];
  localparam int NVEC = 38;
  vec_t vecs[NVEC];

  mw_countdown_timer dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .load(load), .load_mm(load_mm),
    .load_ss(load_ss), .start(start), .stop(stop), .clear(clear),
    .mm(mm), .ss(ss), .running(running), .zero(zero), .done(done)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(input logic t, input logic l, input logic [7:0] lm, input logic [7:0] ls,
                             input logic st, input logic sp, input logic cl,
                             input logic [7:0] em, input logic [7:0] es,
                             input logic r, input logic z, input logic d);
    vec_t x;
    x.tick = t; x.load = l; x.lmm = lm; x.lss = ls; x.start = st; x.stop = sp; x.clear = cl;
    x.emm = em; x.ess = es; x.erun = r; x.ezero = z; x.edone = d;
    return x;
  endfunction

  task automatic drive(input logic t, input logic l, input logic [7:0] lm, input logic [7:0] ls,
                       input logic st, input logic sp, input logic cl);
    tick = t; load = l; load_mm = lm; load_ss = ls; start = st; stop = sp; clear = cl;
  endtask

  task automatic push_exp(input logic [7:0] m, input logic [7:0] s, input logic r, input logic z, input logic d);
    exp_q.push_back({m, s, r, z, d});
  endtask

  task automatic check_out(input string nm);
    obs_t e, a;
    a = {mm, ss, running, zero, done};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: no expected entry queued, got mm=%h ss=%h", nm, mm, ss);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got mm=%h ss=%h run=%b zero=%b done=%b, expected mm=%h ss=%h run=%b zero=%b done=%b",
                 nm, a[18:11], a[10:3], a[2], a[1], a[0], e[18:11], e[10:3], e[2], e[1], e[0]);
      end
    end
  endtask

  // One clocked command cycle: drive at negedge, compare just after the rising edge.
  task automatic step(input string nm, input logic t, input logic l, input logic [7:0] lm, input logic [7:0] ls,
                      input logic st, input logic sp, input logic cl,
                      input logic [7:0] em, input logic [7:0] es, input logic r, input logic z, input logic d);
    @(negedge clk);
    drive(t, l, lm, ls, st, sp, cl);
    push_exp(em, es, r, z, d);
    @(posedge clk);
    #1;
    check_out(nm);
  endtask

  initial begin
    //               tk ld lmm    lss    st sp cl  emm    ess    run z  done
    vecs[0]  = v(0, 1, 8'h01, 8'h05, 0, 0, 0, 8'h01, 8'h05, 0, 0, 0);
    vecs[1]  = v(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h01, 8'h05, 1, 0, 0);
    vecs[2]  = v(1, 0, 8'h00, 8'h00, 0, 0, 0, 8'h01, 8'h04, 1, 0, 0);
    vecs[3]  = v(1, 0, 8'h00, 8'h00, 0, 0, 0, 8'h01, 8'h03, 1, 0, 0);
    vecs[4]  = v(1, 0, 8'h00, 8'h00, 0, 0, 0, 8'h01, 8'h02, 1, 0, 0);
    vecs[5]  = v(1, 0, 8'h00, 8'h00, 0, 0, 0, 8'h01, 8'h01, 1, 0, 0);
    vecs[6]  = v(1, 0, 8'h00, 8'h00, 0, 0, 0, 8'h01, 8'h00, 1, 0, 0);
    vecs[7]  = v(1, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h59, 1, 0, 0);
    vecs[8]  = v(0, 0, 8'h00, 8'h00, 0, 1, 0, 8'h00, 8'h59, 0, 0, 0);
    vecs[9]  = v(0, 1, 8'h00, 8'h02, 0, 0, 0, 8'h00, 8'h02, 0, 0, 0);
    vecs[10] = v(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h02, 1, 0, 0);
    vecs[11] = v(1, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h01, 1, 0, 0);
    vecs[12] = v(1, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 1, 1);
    vecs[13] = v(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0);
    vecs[14] = v(1, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0);
    vecs[15] = v(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0, 1, 0);
    vecs[16] = v(1, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0, 1, 0);
    vecs[17] = v(0, 1, 8'h10, 8'h00, 0, 0, 0, 8'h10, 8'h00, 0, 0, 0);
    vecs[18] = v(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h10, 8'h00, 1, 0, 0);
    vecs[19] = v(1, 0, 8'h00, 8'h00, 0, 0, 0, 8'h09, 8'h59, 1, 0, 0);
    vecs[20] = v(0, 0, 8'h00, 8'h00, 0, 1, 0, 8'h09, 8'h59, 0, 0, 0);
    vecs[21] = v(0, 1, 8'h03, 8'h00, 0, 0, 0, 8'h03, 8'h00, 0, 0, 0);
    vecs[22] = v(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h03, 8'h00, 1, 0, 0);
    vecs[23] = v(1, 0, 8'h00, 8'h00, 0, 0, 0, 8'h02, 8'h59, 1, 0, 0);
    vecs[24] = v(1, 0, 8'h00, 8'h00, 0, 1, 0, 8'h02, 8'h59, 0, 0, 0);
    vecs[25] = v(1, 0, 8'h00, 8'h00, 0, 0, 0, 8'h02, 8'h59, 0, 0, 0);
    vecs[26] = v(1, 0, 8'h00, 8'h00, 0, 0, 0, 8'h02, 8'h59, 0, 0, 0);
    vecs[27] = v(1, 0, 8'h00, 8'h00, 0, 0, 0, 8'h02, 8'h59, 0, 0, 0);
    vecs[28] = v(1, 0, 8'h00, 8'h00, 1, 0, 0, 8'h02, 8'h59, 1, 0, 0);
    vecs[29] = v(1, 0, 8'h00, 8'h00, 0, 0, 0, 8'h02, 8'h58, 1, 0, 0);
    vecs[30] = v(0, 0, 8'h00, 8'h00, 0, 1, 0, 8'h02, 8'h58, 0, 0, 0);
    vecs[31] = v(0, 1, 8'h7C, 8'h9F, 0, 0, 0, 8'h79, 8'h59, 0, 0, 0);
    vecs[32] = v(0, 0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00, 0, 1, 0);
    vecs[33] = v(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0, 1, 0);
    vecs[34] = v(0, 1, 8'h00, 8'h03, 0, 0, 0, 8'h00, 8'h03, 0, 0, 0);
    vecs[35] = v(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h03, 1, 0, 0);
    vecs[36] = v(1, 1, 8'h05, 8'h00, 0, 0, 0, 8'h00, 8'h03, 1, 0, 0);
    vecs[37] = v(1, 0, 8'h00, 8'h00, 0, 0, 1, 8'h00, 8'h00, 0, 1, 0);

    #2;
    push_exp(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    check_out("reset_values");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].tick, vecs[i].load, vecs[i].lmm, vecs[i].lss,
            vecs[i].start, vecs[i].stop, vecs[i].clear);
      push_exp(vecs[i].emm, vecs[i].ess, vecs[i].erun, vecs[i].ezero, vecs[i].edone);
      @(posedge clk);
      #1;
      check_out($sformatf("vec%0d", i));
    end

    // Asynchronous reset in the middle of a run, between clock edges.
    step("ar_load",  0, 1, 8'h05, 8'h30, 0, 0, 0, 8'h05, 8'h30, 0, 0, 0);
    step("ar_start", 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h05, 8'h30, 1, 0, 0);
    step("ar_tick",  1, 0, 8'h00, 8'h00, 0, 0, 0, 8'h05, 8'h29, 1, 0, 0);
    @(negedge clk);
    drive(0, 0, 8'h00, 8'h00, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    push_exp(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    check_out("async_reset_immediate");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset_tick", 1, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0);
    step("post_reset_load", 0, 1, 8'h00, 8'h10, 0, 0, 0, 8'h00, 8'h10, 0, 0, 0);

    @(negedge clk);
    drive(0, 0, 8'h00, 8'h00, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
